// File: rtl/dmem_port_arbiter.sv
// Purpose: round-robin arbiter that hands the single data-memory port to the
//          controller (C) or the debug/DMA loader (D) for whole bursts.
// Latency: first beat 1 cycle after req is seen in IDLE; read data 1 cycle after its beat.
// Backpressure: none inside a burst; a port waits, req held, until its gnt beats arrive.
// Ports:
//   Clk, ResetN                     clock, async active-low reset
//   c_req/c_wr/c_addr/c_len/c_wdata port C request (len = beats-1), wdata used live
//   c_gnt/c_rvalid/c_done           port C beat strobe, read valid, burst-done pulse
//   d_*                             port D, same meaning as port C
//   rdata                           shared read data, qualified by *_rvalid
//   mem_addr/mem_wr/mem_wdata       to the data memory
//   mem_rdata                       from the data memory (synchronous, 1-cycle)
//   busy, owner                     not-IDLE flag, current/most recent grantee (1 = D)
module dmem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int LW = 4
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          c_req,
  input  logic          c_wr,
  input  logic [AW-1:0] c_addr,
  input  logic [LW-1:0] c_len,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic          c_done,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [LW-1:0] d_len,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          owner_q;   // 0 = C, 1 = D
  logic          lat_wr;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] cnt_q;     // beats remaining after the current one
  logic          rv_c_q;
  logic          rv_d_q;
  logic          win_any;
  logic          win_d;

  // With both requesting, the port that did not own the last burst wins.
  // Reset leaves owner at D so C wins the very first contention.
  assign win_any = c_req || d_req;
  assign win_d   = d_req && (!c_req || !owner_q);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    c_done    = 1'b0;
    d_done    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_nxt = BURST;
        end
      end
      BURST: begin
        busy      = 1'b1;
        c_gnt     = !owner_q;
        d_gnt     = owner_q;
        mem_wr    = lat_wr;
        // Write data follows the winner live so it can change every beat.
        mem_wdata = owner_q ? d_wdata : c_wdata;
        if (cnt_q == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        c_done    = !owner_q;
        d_done    = owner_q;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      owner_q <= 1'b1;
      lat_wr  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rv_c_q  <= 1'b0;
      rv_d_q  <= 1'b0;
    end else begin
      // A read beat now means memory data is on mem_rdata next cycle.
      rv_c_q <= (state == BURST) && !lat_wr && !owner_q;
      rv_d_q <= (state == BURST) && !lat_wr && owner_q;
      if (state == IDLE && win_any) begin
        owner_q <= win_d;
        lat_wr  <= win_d ? d_wr   : c_wr;
        addr_q  <= win_d ? d_addr : c_addr;
        cnt_q   <= win_d ? d_len  : c_len;
      end else if (state == BURST) begin
        addr_q <= addr_q + AW'(1);   // wraps naturally at 2^AW
        cnt_q  <= cnt_q - LW'(1);
      end
    end
  end

  assign mem_addr = addr_q;
  assign owner    = owner_q;
  assign c_rvalid = rv_c_q;
  assign d_rvalid = rv_d_q;
  // The RAM already registers its output; rdata is that word, zeroed when not valid.
  assign rdata    = (rv_c_q || rv_d_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Purpose: testbench for dmem_port_arbiter with a cycle-schedule reference model.
// Latency: model predicts beats at req+1, done at req+len+2, next arbitration at req+len+3.
// Backpressure: not applicable; requests and write data are driven freely every cycle.
module tb_dmem_port_arbiter;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic        c_req, c_wr, d_req, d_wr;
  logic [7:0]  c_addr, d_addr;
  logic [3:0]  c_len, d_len;
  logic [15:0] c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, c_done, d_gnt, d_rvalid, d_done;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic        mem_wr, busy, owner;

  always #5 Clk = ~Clk;

  dmem_port_arbiter #(.AW(8), .DW(16), .LW(4)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_len(c_len), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_done(c_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_done(d_done),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  // Synchronous RAM plus a preload path for setting up contents.
  logic [15:0] tb_mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h00;
  logic [15:0] pl_dat = 16'h0000;
  always @(posedge Clk) begin
    if (pl_en) tb_mem[pl_addr] <= pl_dat;
    else if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr];
  end

  // Reference: per-cycle expected events, filled in when a burst is predicted.
  typedef struct packed {
    logic        beat;
    logic        port;
    logic        wr;
    logic [7:0]  addr;
    logic        done;
    logic        busy;
    logic        rv;
    logic [15:0] rd;
    logic        own_set;
    logic        own;
  } exp_t;

  exp_t        ex [0:4095];
  logic [15:0] ref_mem [0:255];
  int          cyc;
  int          m_free;
  logic        cur_owner;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    ref_mem[a] = d;
    @(posedge Clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_wr = 0; c_addr = 0; c_len = 0; c_wdata = 0;
    d_req = 0; d_wr = 0; d_addr = 0; d_len = 0; d_wdata = 0;
  endtask

  task automatic do_reset();
    ResetN = 1'b0;
    idle_inputs();
    @(negedge Clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'({c_gnt, d_gnt}), 32'd0);
    chk("rst_rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
    chk("rst_done", 32'({c_done, d_done}), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_owner", 32'(owner), 32'd1);
    @(posedge Clk); #1;
    ResetN = 1'b1;
    for (int i = 0; i < 4096; i++) ex[i] = '0;
    cyc = 0; m_free = 0; cur_owner = 1'b1;
  endtask

  task automatic model_and_check();
    exp_t        e;
    logic        w, wr;
    logic [7:0]  a;
    int          l;
    logic [15:0] wd;
    if (ex[cyc].own_set) cur_owner = ex[cyc].own;
    if (cyc >= m_free && (c_req || d_req)) begin
      w  = (c_req && d_req) ? !cur_owner : d_req;
      a  = w ? d_addr : c_addr;
      l  = int'(w ? d_len : c_len);
      wr = w ? d_wr : c_wr;
      for (int i = 0; i <= l; i++) begin
        ex[cyc+1+i].beat = 1'b1;
        ex[cyc+1+i].port = w;
        ex[cyc+1+i].wr   = wr;
        ex[cyc+1+i].addr = a + 8'(i);
        ex[cyc+1+i].busy = 1'b1;
      end
      ex[cyc+2+l].done = 1'b1;
      ex[cyc+2+l].port = w;
      ex[cyc+2+l].busy = 1'b1;
      ex[cyc+1].own_set = 1'b1;
      ex[cyc+1].own     = w;
      m_free = cyc + 3 + l;
    end
    e = ex[cyc];
    chk("busy", 32'(busy), 32'(e.busy));
    chk("c_gnt", 32'(c_gnt), 32'(e.beat && !e.port));
    chk("d_gnt", 32'(d_gnt), 32'(e.beat && e.port));
    chk("mem_wr", 32'(mem_wr), 32'(e.beat && e.wr));
    chk("c_done", 32'(c_done), 32'(e.done && !e.port));
    chk("d_done", 32'(d_done), 32'(e.done && e.port));
    chk("c_rvalid", 32'(c_rvalid), 32'(e.rv && !e.port));
    chk("d_rvalid", 32'(d_rvalid), 32'(e.rv && e.port));
    chk("owner", 32'(owner), 32'(cur_owner));
    if (e.rv) chk("rdata", 32'(rdata), 32'(e.rd));
    if (e.beat) begin
      wd = e.port ? d_wdata : c_wdata;
      chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(wd));
      if (e.wr) begin
        ref_mem[e.addr] = wd;
      end else begin
        ex[cyc+1].rv   = 1'b1;
        ex[cyc+1].port = e.port;
        ex[cyc+1].rd   = ref_mem[e.addr];
      end
    end
  endtask

  task automatic step();
    @(negedge Clk);
    model_and_check();
    @(posedge Clk); #1;
    cyc++;
  endtask

  task automatic rand_inputs();
    c_req = ($urandom_range(0, 3) != 0);
    c_wr = 1'($urandom_range(0, 1));
    c_addr = 8'($urandom);
    c_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
    c_wdata = 16'($urandom);
    d_req = ($urandom_range(0, 3) != 0);
    d_wr = 1'($urandom_range(0, 1));
    d_addr = 8'($urandom);
    d_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
    d_wdata = 16'($urandom);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    for (int i = 0; i < 256; i++) preload(8'(i), 16'(i * 37 + 5));

    // C-only single-beat read of a known word.
    preload(8'h10, 16'hBEEF);
    do_reset();
    c_req = 1; c_wr = 0; c_addr = 8'h10; c_len = 4'd0;
    step();
    c_req = 0;
    repeat (4) step();

    // D write burst that wraps the address.
    d_req = 1; d_wr = 1; d_addr = 8'hFE; d_len = 4'd2;
    step();
    d_req = 0;
    d_wdata = 16'h1111; step();
    d_wdata = 16'h2222; step();
    d_wdata = 16'h3333; step();
    d_wdata = 16'h0000;
    repeat (3) step();
    chk("wrap_mem_fe", 32'(tb_mem[8'hFE]), 32'h1111);
    chk("wrap_mem_ff", 32'(tb_mem[8'hFF]), 32'h2222);
    chk("wrap_mem_00", 32'(tb_mem[8'h00]), 32'h3333);

    // Contention out of reset: alternation C, D, C, D.
    do_reset();
    c_req = 1; c_wr = 0; c_addr = 8'h80; c_len = 4'd1;
    d_req = 1; d_wr = 0; d_addr = 8'hC0; d_len = 4'd1;
    repeat (18) step();
    idle_inputs();
    repeat (4) step();

    // C read burst of 4 with req dropped after the first beat.
    c_req = 1; c_wr = 0; c_addr = 8'h30; c_len = 4'd3;
    step();
    step();
    c_req = 0;
    repeat (7) step();

    // Request fields change after the grant: burst keeps the sampled address.
    c_req = 1; c_wr = 0; c_addr = 8'h20; c_len = 4'd1;
    step();
    c_addr = 8'h40; c_len = 4'd7; c_wr = 1;
    step();
    c_req = 0;
    repeat (4) step();

    // Reset in the middle of a D write burst.
    preload(8'h53, 16'hA5A5);
    do_reset();
    d_req = 1; d_wr = 1; d_addr = 8'h50; d_len = 4'd7; d_wdata = 16'h7777;
    step();
    d_req = 0;
    repeat (3) step();
    #2 ResetN = 1'b0;
    #1;
    chk("abort_mem_wr", 32'(mem_wr), 32'd0);
    chk("abort_d_gnt", 32'(d_gnt), 32'd0);
    chk("abort_d_done", 32'(d_done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    do_reset();
    chk("abort_mem_53", 32'(tb_mem[8'h53]), 32'hA5A5);
    c_req = 1; c_wr = 0; c_addr = 8'h53; c_len = 4'd0;
    step();
    c_req = 0;
    repeat (4) step();

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rand_inputs();
      step();
    end
    idle_inputs();
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the datapath's single data-memory port between two requesters: port C (processor controller, load/store) and port D (debug/DMA loader used to preload or dump data memory).
- Arbitrates round-robin, owns the port for a whole burst, auto-increments the address, and returns per-beat read data with the memory's 1-cycle read latency.
- Sits between the controller/loader and the data memory; the controller stalls on its grant.

Parameters:
AW, 8, data-memory address width
DW, 16, data word width
LW, 4, burst-length field width; bursts are 1..2^LW beats

Ports:
Clk  in  1  processor clock, rising edge
ResetN  in  1  asynchronous active-low reset
c_req  in  1  port C request; held high until c_done
c_wr  in  1  port C direction: 1 = write, 0 = read
c_addr  in  AW  port C start address
c_len  in  LW  port C beat count minus 1
c_wdata  in  DW  port C write data for the current beat
c_gnt  out  1  port C beat strobe: high during each granted beat
c_rvalid  out  1  port C read data valid on rdata
c_done  out  1  one-cycle pulse when the port C burst completes
d_req, d_wr, d_addr, d_len, d_wdata  in  1/1/AW/LW/DW  port D, same semantics as port C
d_gnt, d_rvalid, d_done  out  1 each  port D, same semantics as port C
rdata  out  DW  read data, shared by both ports, qualified by *_rvalid
mem_addr  out  AW  data-memory address (datapath D_Addr)
mem_wr  out  1  data-memory write enable (datapath D_wr)
mem_wdata  out  DW  data-memory write data
mem_rdata  in  DW  data-memory read data; synchronous RAM, valid 1 cycle after the address
busy  out  1  high in any state other than IDLE
owner  out  1  0 = C, 1 = D; the current or most recent grantee

Behaviour:
- Reset (asynchronous, ResetN = 0):
  - state = IDLE; all gnt/rvalid/done/mem_wr/busy = 0; mem_addr = 0; mem_wdata = 0; rdata = 0.
  - owner = 1, so port C wins the first contention.
- States: IDLE, BURST, DONE.
- IDLE:
  - Arbitration samples c_req and d_req each cycle.
  - If only one request is high, that port wins.
  - If both are high, the port that is not owner wins.
  - On a win, latch the winner's wr, addr and len; set owner and a beat counter = len; go to BURST.
  - Grant latency is 1 cycle from req sampled high to the first gnt.
- BURST:
  - Winner's gnt = 1 every cycle. mem_addr = latched address.
  - mem_wr = latched wr. mem_wdata = winner's *_wdata, combinational pass-through.
  - After each beat the address increments modulo 2^AW (0xFF wraps to 0x00) and the counter decrements.
  - When the counter = 0 at a beat, that beat is the last; go to DONE.
  - Burst duration is exactly len+1 cycles.
- DONE (1 cycle):
  - gnt = 0, mem_wr = 0; winner's *_done = 1; busy = 1; return to IDLE.
  - Next arbitration happens in the following IDLE cycle.
  - Minimum request-to-request turnaround: one IDLE cycle, so consecutive bursts from one port are 2 cycles apart.
- Read data:
  - For a read beat at cycle t, rdata is registered from mem_rdata and the winner's *_rvalid = 1 at cycle t+1.
  - The last read beat's rvalid coincides with *_done in DONE.
  - Write bursts produce no rvalid.
- mem_wr is 0 in IDLE and DONE regardless of inputs.
- Non-winner outputs: gnt/rvalid/done stay 0 for the entire transaction.
- Request rules:
  - Dropping *_req mid-burst is ignored; the burst runs to completion and done still pulses.
  - Request fields are sampled only in the arbitration cycle; later changes to addr/len/wr have no effect.
  - *_wdata is used live, per beat.
- A request that stays high through DONE is re-arbitrated in the next IDLE cycle under round-robin. A continuously requesting pair therefore alternates C, D, C, ...
- Reset mid-burst: immediate abort; no done pulse; memory writes stop the same instant.

Test Plan:
1. C-only read, c_addr = 0x10, c_len = 0, memory[0x10] = 0xBEEF:
   - c_gnt high 1 cycle with mem_addr = 0x10, mem_wr = 0.
   - Next cycle: c_rvalid = 1, rdata = 0xBEEF, c_done = 1.
2. D write burst, d_addr = 0xFE, d_len = 2, d_wdata = 0x1111 / 0x2222 / 0x3333 on successive beats:
   - mem_addr = 0xFE, 0xFF, 0x00 with mem_wr = 1 for exactly 3 cycles.
   - Memory holds those values at those addresses; d_done pulses once; no d_rvalid.
3. Out of reset, c_req and d_req asserted together with len = 1 and held:
   - Grant order C, D, C, D.
   - Each burst is 2 gnt cycles followed by DONE then one IDLE cycle.
   - owner toggles after each grant.
4. C read burst with len = 3; drop c_req after the first beat:
   - 4 beats still issued at sequential addresses.
   - 4 c_rvalid pulses; c_done pulses after the final beat.
5. D write burst with len = 7; pull ResetN low at beat 3:
   - mem_wr = 0 and d_gnt = 0 immediately; no d_done.
   - After release, busy = 0 and owner = 1; a fresh c_req is granted.
6. c_addr changed from 0x20 to 0x40 one cycle after grant, len = 1:
   - Beats go to 0x20 and 0x21.
